// File: rtl/fb_bram_arbiter.sv
// Single-port frame-buffer BRAM arbiter: display reader vs. pixel writer.
// Reader has priority in active video, writer in vsync, with a bounded-starvation forced write grant.
module fb_bram_arbiter #(
    parameter int HSIZE      = 640,
    parameter int VSIZE      = 480,
    parameter int AW         = 19,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          Vsync,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout,
    output logic [15:0]   rd_stall_cnt,
    output logic          wr_oob
);

    localparam logic [AW-1:0] PIX_LIMIT = AW'(HSIZE * VSIZE);
    localparam logic [7:0]    WAIT_MAX  = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_BLANK,
        MODE_FORCE
    } mode_t;

    mode_t       mode, mode_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic        vsync_d;
    logic        rd_pipe;
    logic        rd_grant, wr_grant;
    logic        wr_in_range;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) mode <= MODE_NORMAL;
        else       mode <= mode_nxt;
    end

    // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        wait_nxt = 8'd0;
        mode_nxt = Vsync ? MODE_NORMAL : MODE_BLANK;

        // Vsync as sampled on this edge already selects the priority for this grant.
        if (mode == MODE_FORCE && wr_req) begin
            wr_grant = 1'b1;
        end else if (Vsync) begin
            if (rd_req)      rd_grant = 1'b1;
            else if (wr_req) wr_grant = 1'b1;
        end else begin
            if (wr_req)      wr_grant = 1'b1;
            else if (rd_req) rd_grant = 1'b1;
        end

        if (wr_req && !wr_grant)
            wait_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + 8'd1;

        if (wait_nxt == WAIT_MAX)
            mode_nxt = MODE_FORCE;
    end

    assign wr_in_range = (wr_addr < PIX_LIMIT);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt  <= 8'd0;
            rd_ack    <= 1'b0;
            wr_ack    <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            wr_oob    <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            rd_ack   <= rd_grant;
            wr_ack   <= wr_grant;
            bram_en  <= 1'b0;
            bram_we  <= 1'b0;
            if (wr_grant) begin
                if (wr_in_range) begin
                    bram_en   <= 1'b1;
                    bram_we   <= 1'b1;
                    bram_addr <= wr_addr;
                    bram_din  <= wr_data;
                end else begin
                    wr_oob <= 1'b1;
                end
            end else if (rd_grant) begin
                bram_en   <= 1'b1;
                bram_addr <= rd_addr;
            end
        end
    end

    // Read return path: BRAM samples the command one edge after the ack, data is captured one edge later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_pipe  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe  <= rd_ack;
            rd_valid <= rd_pipe;
            if (rd_pipe)
                rd_data <= bram_dout;
        end
    end

    // Stall counter restarts at the start of each vertical sync pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vsync_d      <= 1'b1;
            rd_stall_cnt <= 16'd0;
        end else begin
            vsync_d <= Vsync;
            if (vsync_d && !Vsync)
                rd_stall_cnt <= 16'd0;
            else if (rd_req && !rd_grant && rd_stall_cnt != 16'hFFFF)
                rd_stall_cnt <= rd_stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/fb_bram_arbiter.md
# fb_bram_arbiter

Single-port frame-buffer BRAM arbiter that shares one BRAM port between the display scan-out reader and a pixel writer (camera/CPU fill path). Sits between the display address generator and the BRAM: issues at most one access per cycle, gives the reader priority during active video and the writer priority during vertical sync, and bounds writer starvation. Also keeps a per-frame reader-stall counter and a sticky out-of-range write flag for debug.

## Interface
- HSIZE, 640, active pixels per line
- VSIZE, 480, active lines per frame
- AW, 19, BRAM address width (must hold HSIZE*VSIZE-1)
- DW, 16, pixel width (RGB565)
- STARVE_MAX, 8, consecutive denied writer cycles before a forced writer grant (1..255)

- CLK  in  1  single clock; BRAM runs on CLK
- RESET  in  1  asynchronous, active-high reset
- Vsync  in  1  vertical sync, active low (low = sync pulse)
- rd_req  in  1  reader request; rd_addr held stable until rd_ack
- rd_addr  in  AW  reader address
- rd_ack  out  1  one-cycle pulse: read issued
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  DW  read pixel
- wr_req  in  1  writer request; wr_addr/wr_data held stable until wr_ack
- wr_addr  in  AW  writer address
- wr_data  in  DW  writer pixel
- wr_ack  out  1  one-cycle pulse: write accepted
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  AW  BRAM address
- bram_din  out  DW  BRAM write data
- bram_dout  in  DW  BRAM read data, one cycle after bram_en (synchronous read)
- rd_stall_cnt  out  16  cycles in the previous/current frame with rd_req high and not granted
- wr_oob  out  1  sticky: a write with wr_addr >= HSIZE*VSIZE was accepted

## Operation
- One grant per clock edge; all outputs registered. Winner's ack and bram_* command load on the same edge.
- Mode FSM (registered), evaluated per edge:
  - NORMAL: Vsync high. Reader wins if rd_req; else writer if wr_req. Go FORCE when wait_cnt reaches STARVE_MAX; go BLANK when Vsync low.
  - BLANK: Vsync low. Writer wins if wr_req; else reader. Return NORMAL when Vsync high.
  - FORCE: writer granted unconditionally (wr_req is necessarily high); next state NORMAL or BLANK per Vsync.
- wait_cnt (8 bit): +1 each edge wr_req high and writer not granted; cleared on writer grant or wr_req low; never exceeds STARVE_MAX.
- Write grant: wr_ack=1; if wr_addr < HSIZE*VSIZE then bram_en=1, bram_we=1, bram_addr=wr_addr, bram_din=wr_data; else bram_en=0, set wr_oob (cleared only by RESET).
- Read grant: rd_ack=1, bram_en=1, bram_we=0, bram_addr=rd_addr. No range check on reads.
- No grant: bram_en=0, bram_we=0; bram_addr/bram_din hold.
- A req still high in its ack cycle is a new request, sampled with the address/data present then (back-to-back allowed, one per cycle per requester).
- rd_stall_cnt: +1 per edge with rd_req high and reader not granted; saturates at 16'hFFFF; cleared to 0 on Vsync falling edge (registered Vsync_d high, Vsync low); clear beats increment.

## Timing
- Reset: rd_ack, rd_valid, wr_ack, bram_en, bram_we, wr_oob = 0; rd_data, bram_addr, bram_din, rd_stall_cnt, wait_cnt = 0; mode NORMAL; Vsync_d = 1.
- Request sampled at edge k -> ack and bram command visible in cycle k..k+1.
- Read: bram_en at edge k, BRAM data after edge k+1, rd_data/rd_valid registered at edge k+2 (rd_valid two cycles after rd_ack).
- Write: committed into BRAM at edge k+1.
- Vsync used as sampled at each edge; mode change affects the grant on that same edge.
- RESET mid-read: in-flight read discarded, no rd_valid after RESET deasserts.
- Reader worst-case wait in NORMAL: 1 cycle per STARVE_MAX+1 cycles.

## Test plan
- rd_req held, rd_addr=0..3, Vsync high -> rd_ack every cycle, rd_valid stream 2 cycles behind with BRAM model data for 0..3.
- Write 0xF800 to addr 100, then read 100 -> wr_ack 1 cycle, rd_data=0xF800.
- rd_req and wr_req both held high, Vsync high, STARVE_MAX=8 -> writer granted once every 9 cycles; rd_stall_cnt increments by 1 per forced grant.
- Both held high, Vsync low -> writer granted every cycle, reader none; Vsync falling edge clears rd_stall_cnt to 0.
- wr_addr=307200 -> wr_ack=1, bram_en=0, wr_oob=1 stays high until RESET.
- RESET asserted one cycle after a read grant -> all outputs 0 immediately, no rd_valid afterwards.
